// File: rtl/mips_control_unit.sv
// Multi-cycle control unit for the integer datapath: fetches into an internal
// IR, then walks decode / execute / memory / write-back states, driving the
// datapath control word, memory strobes and PC controls.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_FETCH   | instruction memory read, IR load, PC += 4
// S_DECODE  | register addresses presented, opcode/funct legality check
// S_EXEC    | ALU op, HI/LO load, branch resolve, jump
// S_WB      | register-file write of Y_lo / HI / LO
// S_MEM_RD  | data memory read, address held
// S_WB_MEM  | register-file write of load data (DY)
// S_MEM_WR  | data memory write, address held
// S_BR_TAKE | load PC with branch target
// S_HALT    | stopped until reset; trap holds the cause
module mips_control_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IM_OUT,
   input  logic        C,
   input  logic        V,
   input  logic        N,
   input  logic        Z,
   output logic        im_cs,
   output logic        im_rd,
   output logic        pc_ld,
   output logic        pc_inc,
   output logic [1:0]  pc_sel,
   output logic        ir_ld,
   output logic        D_En,
   output logic [4:0]  D_Addr,
   output logic [4:0]  S_Addr,
   output logic [4:0]  T_Addr,
   output logic [4:0]  FS,
   output logic        HILO_ld,
   output logic        T_Sel,
   output logic        imm_sext,
   output logic [2:0]  Y_Sel,
   output logic        dm_cs,
   output logic        dm_rd,
   output logic        dm_wr,
   output logic [3:0]  psr,
   output logic        halted,
   output logic [1:0]  trap
);

   typedef enum logic [3:0] {
      S_FETCH, S_DECODE, S_EXEC, S_WB, S_MEM_RD,
      S_WB_MEM, S_MEM_WR, S_BR_TAKE, S_HALT
   } state_t;

   typedef enum logic [3:0] {
      K_ALU, K_MULDIV, K_MFHI, K_MFLO, K_ADDI, K_ORI,
      K_LW, K_SW, K_BEQ, K_BNE, K_J, K_ILL
   } kind_t;

   state_t      state, next_state;
   kind_t       kind;
   logic [31:0] ir;
   logic [4:0]  alu_fs;
   logic        ovf_chk;
   logic        psr_upd;
   logic        ovf_trap;

   logic [5:0]  op, funct;
   logic [4:0]  rs, rt, rd, shamt;

   assign op    = ir[31:26];
   assign rs    = ir[25:21];
   assign rt    = ir[20:16];
   assign rd    = ir[15:11];
   assign shamt = ir[10:6];
   assign funct = ir[5:0];

   // Instruction classification and ALU function from the IR.
   // Shifts are not supported, so a nonzero shamt on an R-type is an
   // illegal encoding.
   always_comb begin
      kind    = K_ILL;
      alu_fs  = 5'h00;
      ovf_chk = 1'b0;
      case (op)
         6'h00: begin
            if (shamt == 5'd0) begin
               case (funct)
                  6'h20: begin kind = K_ALU; alu_fs = 5'h02; ovf_chk = 1'b1; end
                  6'h21: begin kind = K_ALU; alu_fs = 5'h03; end
                  6'h22: begin kind = K_ALU; alu_fs = 5'h04; ovf_chk = 1'b1; end
                  6'h23: begin kind = K_ALU; alu_fs = 5'h05; end
                  6'h24: begin kind = K_ALU; alu_fs = 5'h08; end
                  6'h25: begin kind = K_ALU; alu_fs = 5'h09; end
                  6'h26: begin kind = K_ALU; alu_fs = 5'h0A; end
                  6'h27: begin kind = K_ALU; alu_fs = 5'h0B; end
                  6'h2A: begin kind = K_ALU; alu_fs = 5'h06; end
                  6'h2B: begin kind = K_ALU; alu_fs = 5'h07; end
                  6'h18: begin kind = K_MULDIV; alu_fs = 5'h1E; end
                  6'h1A: begin kind = K_MULDIV; alu_fs = 5'h1F; end
                  6'h10: kind = K_MFHI;
                  6'h12: kind = K_MFLO;
                  default: kind = K_ILL;
               endcase
            end
         end
         6'h08: begin kind = K_ADDI; alu_fs = 5'h02; ovf_chk = 1'b1; end
         6'h0D: begin kind = K_ORI;  alu_fs = 5'h09; end
         6'h23: begin kind = K_LW;   alu_fs = 5'h02; end
         6'h2B: begin kind = K_SW;   alu_fs = 5'h02; end
         6'h04: begin kind = K_BEQ;  alu_fs = 5'h04; end
         6'h05: begin kind = K_BNE;  alu_fs = 5'h04; end
         6'h02: kind = K_J;
         default: kind = K_ILL;
      endcase
   end

   assign psr_upd  = (kind == K_ALU) || (kind == K_ADDI) ||
                     (kind == K_ORI) || (kind == K_MULDIV);
   assign ovf_trap = ovf_chk & V;

   // State, IR, flags and trap cause registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_FETCH;
         ir    <= 32'h0;
         psr   <= 4'h0;
         trap  <= 2'b00;
      end else begin
         state <= next_state;
         if (state == S_FETCH)
            ir <= IM_OUT;
         if ((state == S_EXEC) && psr_upd)
            psr <= {C, V, N, Z};
         if ((state == S_DECODE) && (kind == K_ILL))
            trap <= 2'b01;
         else if ((state == S_EXEC) && ovf_trap)
            trap <= 2'b10;
      end
   end

   // Next state and control word; everything is forced low while in reset.
   always_comb begin
      next_state = state;
      im_cs      = 1'b0;
      im_rd      = 1'b0;
      pc_ld      = 1'b0;
      pc_inc     = 1'b0;
      pc_sel     = 2'b00;
      ir_ld      = 1'b0;
      D_En       = 1'b0;
      D_Addr     = 5'd0;
      S_Addr     = 5'd0;
      T_Addr     = 5'd0;
      FS         = 5'h00;
      HILO_ld    = 1'b0;
      T_Sel      = 1'b0;
      imm_sext   = 1'b0;
      Y_Sel      = 3'b000;
      dm_cs      = 1'b0;
      dm_rd      = 1'b0;
      dm_wr      = 1'b0;
      halted     = 1'b0;
      if (reset) begin
         case (state)
            S_FETCH: begin
               im_cs      = 1'b1;
               im_rd      = 1'b1;
               ir_ld      = 1'b1;
               pc_inc     = 1'b1;
               next_state = S_DECODE;
            end
            S_DECODE: begin
               S_Addr     = rs;
               T_Addr     = rt;
               next_state = (kind == K_ILL) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
               S_Addr = rs;
               T_Addr = rt;
               FS     = alu_fs;
               case (kind)
                  K_ALU: begin
                     T_Sel      = 1'b1;
                     next_state = ovf_trap ? S_HALT : S_WB;
                  end
                  K_ADDI: begin
                     imm_sext   = 1'b1;
                     next_state = ovf_trap ? S_HALT : S_WB;
                  end
                  K_ORI:            next_state = S_WB;
                  K_MFHI, K_MFLO:   next_state = S_WB;
                  K_LW: begin
                     imm_sext   = 1'b1;
                     next_state = S_MEM_RD;
                  end
                  K_SW: begin
                     imm_sext   = 1'b1;
                     next_state = S_MEM_WR;
                  end
                  K_MULDIV: begin
                     T_Sel      = 1'b1;
                     HILO_ld    = 1'b1;
                     next_state = S_FETCH;
                  end
                  K_BEQ: begin
                     T_Sel      = 1'b1;
                     next_state = Z ? S_BR_TAKE : S_FETCH;
                  end
                  K_BNE: begin
                     T_Sel      = 1'b1;
                     next_state = Z ? S_FETCH : S_BR_TAKE;
                  end
                  K_J: begin
                     pc_sel     = 2'b10;
                     pc_ld      = 1'b1;
                     next_state = S_FETCH;
                  end
                  default:          next_state = S_HALT;
               endcase
            end
            S_WB: begin
               // Operand controls stay at their EXEC values so Y_lo is stable.
               S_Addr     = rs;
               T_Addr     = rt;
               FS         = alu_fs;
               D_En       = 1'b1;
               next_state = S_FETCH;
               case (kind)
                  K_ALU: begin
                     T_Sel  = 1'b1;
                     D_Addr = rd;
                     Y_Sel  = 3'b101;
                  end
                  K_ADDI: begin
                     imm_sext = 1'b1;
                     D_Addr   = rt;
                     Y_Sel    = 3'b101;
                  end
                  K_ORI: begin
                     D_Addr = rt;
                     Y_Sel  = 3'b101;
                  end
                  K_MFHI: begin
                     D_Addr = rd;
                     Y_Sel  = 3'b111;
                  end
                  K_MFLO: begin
                     D_Addr = rd;
                     Y_Sel  = 3'b110;
                  end
                  default: D_En = 1'b0;
               endcase
            end
            S_MEM_RD: begin
               S_Addr     = rs;
               T_Addr     = rt;
               FS         = alu_fs;
               imm_sext   = 1'b1;
               dm_cs      = 1'b1;
               dm_rd      = 1'b1;
               next_state = S_WB_MEM;
            end
            S_WB_MEM: begin
               Y_Sel      = 3'b100;
               D_Addr     = rt;
               D_En       = 1'b1;
               next_state = S_FETCH;
            end
            S_MEM_WR: begin
               S_Addr     = rs;
               T_Addr     = rt;
               FS         = alu_fs;
               imm_sext   = 1'b1;
               dm_cs      = 1'b1;
               dm_wr      = 1'b1;
               next_state = S_FETCH;
            end
            S_BR_TAKE: begin
               pc_sel     = 2'b01;
               pc_ld      = 1'b1;
               next_state = S_FETCH;
            end
            S_HALT: begin
               halted     = 1'b1;
               next_state = S_HALT;
            end
            default: next_state = S_FETCH;
         endcase
      end
   end

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed bench for mips_control_unit: each task feeds one instruction from
// FETCH and checks the control word state by state at the falling edge.
module tb_mips_control_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] IM_OUT = 32'h0;
   logic        C = 1'b0, V = 1'b0, N = 1'b0, Z = 1'b0;
   logic        im_cs, im_rd, pc_ld, pc_inc, ir_ld, D_En, HILO_ld, T_Sel, imm_sext;
   logic        dm_cs, dm_rd, dm_wr, halted;
   logic [1:0]  pc_sel, trap;
   logic [4:0]  D_Addr, S_Addr, T_Addr, FS;
   logic [2:0]  Y_Sel;
   logic [3:0]  psr;

   int checks = 0;
   int errors = 0;

   mips_control_unit dut (
      .clk(clk), .reset(reset), .IM_OUT(IM_OUT), .C(C), .V(V), .N(N), .Z(Z),
      .im_cs(im_cs), .im_rd(im_rd), .pc_ld(pc_ld), .pc_inc(pc_inc), .pc_sel(pc_sel),
      .ir_ld(ir_ld), .D_En(D_En), .D_Addr(D_Addr), .S_Addr(S_Addr), .T_Addr(T_Addr),
      .FS(FS), .HILO_ld(HILO_ld), .T_Sel(T_Sel), .imm_sext(imm_sext), .Y_Sel(Y_Sel),
      .dm_cs(dm_cs), .dm_rd(dm_rd), .dm_wr(dm_wr), .psr(psr), .halted(halted), .trap(trap)
   );

   always #5 clk = ~clk;

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      checks++; if ({im_cs, im_rd, ir_ld, pc_inc, pc_ld} !== 5'b0) begin errors++; $display("FAIL rst_strobes got %b want 00000", {im_cs, im_rd, ir_ld, pc_inc, pc_ld}); end
      checks++; if ({Y_Sel, FS, T_Sel} !== 9'b0) begin errors++; $display("FAIL rst_ysel_fs_tsel got %b want 0", {Y_Sel, FS, T_Sel}); end
      checks++; if ({halted, trap, psr, D_En} !== 8'b0) begin errors++; $display("FAIL rst_status got %b want 0", {halted, trap, psr, D_En}); end
      reset = 1'b1;
      #1;
      checks++; if (im_rd !== 1'b1) begin errors++; $display("FAIL rst_release_fetch im_rd got %b want 1", im_rd); end
   endtask

   task automatic test_add();
      IM_OUT = 32'h014B4820; C = 1'b1; V = 1'b0; N = 1'b1; Z = 1'b0;
      #1;
      checks++; if ({ir_ld, pc_inc, im_cs} !== 3'b111) begin errors++; $display("FAIL add_fetch got %b want 111", {ir_ld, pc_inc, im_cs}); end
      @(negedge clk);
      checks++; if ({S_Addr, T_Addr, D_En} !== {5'd10, 5'd11, 1'b0}) begin errors++; $display("FAIL add_decode got %h/%h/%b want a/b/0", S_Addr, T_Addr, D_En); end
      @(negedge clk);
      checks++; if ({FS, T_Sel, D_En} !== {5'h02, 1'b1, 1'b0}) begin errors++; $display("FAIL add_exec got fs=%h tsel=%b den=%b want 02/1/0", FS, T_Sel, D_En); end
      @(negedge clk);
      checks++; if ({D_En, D_Addr, FS, Y_Sel} !== {1'b1, 5'd9, 5'h02, 3'b101}) begin errors++; $display("FAIL add_wb got den=%b d=%0d fs=%h y=%b want 1/9/02/101", D_En, D_Addr, FS, Y_Sel); end
      checks++; if (psr !== 4'b1010) begin errors++; $display("FAIL add_psr got %b want 1010", psr); end
      @(negedge clk);
      checks++; if ({im_rd, D_En} !== 2'b10) begin errors++; $display("FAIL add_next_fetch got %b want 10", {im_rd, D_En}); end
      C = 1'b0; N = 1'b0;
   endtask

   task automatic test_lw();
      IM_OUT = 32'h8D090004;
      @(negedge clk);
      checks++; if (S_Addr !== 5'd8) begin errors++; $display("FAIL lw_decode_s got %0d want 8", S_Addr); end
      @(negedge clk);
      checks++; if ({FS, T_Sel, imm_sext} !== {5'h02, 1'b0, 1'b1}) begin errors++; $display("FAIL lw_exec got fs=%h tsel=%b sext=%b want 02/0/1", FS, T_Sel, imm_sext); end
      @(negedge clk);
      checks++; if ({dm_cs, dm_rd, dm_wr, D_En, S_Addr} !== {4'b1100, 5'd8}) begin errors++; $display("FAIL lw_mem_rd got %b/%0d want 1100/8", {dm_cs, dm_rd, dm_wr, D_En}, S_Addr); end
      @(negedge clk);
      checks++; if ({Y_Sel, D_Addr, D_En, dm_rd} !== {3'b100, 5'd9, 1'b1, 1'b0}) begin errors++; $display("FAIL lw_wb_mem got y=%b d=%0d den=%b rd=%b want 100/9/1/0", Y_Sel, D_Addr, D_En, dm_rd); end
      @(negedge clk);
      checks++; if ({im_rd, D_En} !== 2'b10) begin errors++; $display("FAIL lw_next_fetch got %b want 10", {im_rd, D_En}); end
   endtask

   task automatic test_sw();
      IM_OUT = 32'hAD090004;
      repeat (2) @(negedge clk);
      checks++; if ({FS, imm_sext} !== {5'h02, 1'b1}) begin errors++; $display("FAIL sw_exec got fs=%h sext=%b want 02/1", FS, imm_sext); end
      @(negedge clk);
      checks++; if ({dm_cs, dm_wr, dm_rd, D_En, T_Addr} !== {4'b1100, 5'd9}) begin errors++; $display("FAIL sw_mem_wr got %b/%0d want 1100/9", {dm_cs, dm_wr, dm_rd, D_En}, T_Addr); end
      @(negedge clk);
      checks++; if ({im_rd, dm_wr} !== 2'b10) begin errors++; $display("FAIL sw_next_fetch got %b want 10", {im_rd, dm_wr}); end
   endtask

   task automatic test_branches();
      IM_OUT = 32'h11090003; Z = 1'b1;
      @(negedge clk);
      checks++; if ({S_Addr, T_Addr} !== {5'd8, 5'd9}) begin errors++; $display("FAIL beq_decode got %0d/%0d want 8/9", S_Addr, T_Addr); end
      @(negedge clk);
      checks++; if ({FS, T_Sel, pc_ld} !== {5'h04, 1'b1, 1'b0}) begin errors++; $display("FAIL beq_exec got fs=%h tsel=%b pcld=%b want 04/1/0", FS, T_Sel, pc_ld); end
      @(negedge clk);
      checks++; if ({pc_sel, pc_ld, im_rd} !== 4'b0110) begin errors++; $display("FAIL beq_taken got %b want 0110", {pc_sel, pc_ld, im_rd}); end
      @(negedge clk);
      checks++; if ({im_rd, pc_ld} !== 2'b10) begin errors++; $display("FAIL beq_taken_fetch got %b want 10", {im_rd, pc_ld}); end
      Z = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({im_rd, pc_ld} !== 2'b10) begin errors++; $display("FAIL beq_untaken got %b want 10", {im_rd, pc_ld}); end
      IM_OUT = 32'h15090003; Z = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({pc_sel, pc_ld, im_rd} !== 4'b0110) begin errors++; $display("FAIL bne_taken got %b want 0110", {pc_sel, pc_ld, im_rd}); end
      @(negedge clk);
   endtask

   task automatic test_mult_mfhi();
      IM_OUT = 32'h014B0018;
      repeat (2) @(negedge clk);
      checks++; if ({HILO_ld, FS, D_En} !== {1'b1, 5'h1E, 1'b0}) begin errors++; $display("FAIL mult_exec got hilo=%b fs=%h den=%b want 1/1e/0", HILO_ld, FS, D_En); end
      @(negedge clk);
      checks++; if ({HILO_ld, D_En, im_rd} !== 3'b001) begin errors++; $display("FAIL mult_next_fetch got %b want 001", {HILO_ld, D_En, im_rd}); end
      IM_OUT = 32'h00004810;
      repeat (2) @(negedge clk);
      checks++; if ({HILO_ld, D_En} !== 2'b00) begin errors++; $display("FAIL mfhi_exec got %b want 00", {HILO_ld, D_En}); end
      @(negedge clk);
      checks++; if ({Y_Sel, D_Addr, D_En} !== {3'b111, 5'd9, 1'b1}) begin errors++; $display("FAIL mfhi_wb got y=%b d=%0d den=%b want 111/9/1", Y_Sel, D_Addr, D_En); end
      @(negedge clk);
   endtask

   task automatic test_ori_j();
      IM_OUT = 32'h3509FFFF;
      repeat (2) @(negedge clk);
      checks++; if ({FS, T_Sel, imm_sext} !== {5'h09, 2'b00}) begin errors++; $display("FAIL ori_exec got fs=%h tsel=%b sext=%b want 09/0/0", FS, T_Sel, imm_sext); end
      @(negedge clk);
      checks++; if ({D_Addr, Y_Sel, D_En} !== {5'd9, 3'b101, 1'b1}) begin errors++; $display("FAIL ori_wb got d=%0d y=%b den=%b want 9/101/1", D_Addr, Y_Sel, D_En); end
      @(negedge clk);
      IM_OUT = 32'h08000010;
      repeat (2) @(negedge clk);
      checks++; if ({pc_sel, pc_ld} !== 3'b101) begin errors++; $display("FAIL j_exec got %b want 101", {pc_sel, pc_ld}); end
      @(negedge clk);
      checks++; if ({im_rd, pc_ld} !== 2'b10) begin errors++; $display("FAIL j_next_fetch got %b want 10", {im_rd, pc_ld}); end
   endtask

   task automatic test_overflow();
      IM_OUT = 32'h014B4820; V = 1'b1; C = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if ({halted, trap, D_En, im_rd} !== 5'b11000) begin errors++; $display("FAIL ovf_halt got %b want 11000", {halted, trap, D_En, im_rd}); end
      checks++; if (psr !== 4'b1100) begin errors++; $display("FAIL ovf_psr got %b want 1100", psr); end
      V = 1'b0; C = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if ({halted, trap, D_En, im_rd} !== 5'b11000) begin errors++; $display("FAIL ovf_sticky got %b want 11000", {halted, trap, D_En, im_rd}); end
   endtask

   task automatic test_reset_mid_exec();
      reset = 1'b0;
      #1;
      checks++; if ({halted, trap, psr} !== 7'b0) begin errors++; $display("FAIL halt_reset_clear got %b want 0", {halted, trap, psr}); end
      @(negedge clk);
      reset = 1'b1;
      IM_OUT = 32'h014B4820;
      repeat (2) @(negedge clk);
      checks++; if (FS !== 5'h02) begin errors++; $display("FAIL mid_exec_pre fs got %h want 02", FS); end
      #2; reset = 1'b0; #1;
      checks++; if ({FS, T_Sel, S_Addr, T_Addr, Y_Sel, D_En} !== 20'b0) begin errors++; $display("FAIL mid_exec_zero got %b want 0", {FS, T_Sel, S_Addr, T_Addr, Y_Sel, D_En}); end
      @(negedge clk);
      checks++; if ({D_En, im_rd} !== 2'b00) begin errors++; $display("FAIL mid_exec_no_wb got %b want 00", {D_En, im_rd}); end
      reset = 1'b1;
      #1;
      checks++; if ({im_rd, D_En} !== 2'b10) begin errors++; $display("FAIL mid_exec_release got %b want 10", {im_rd, D_En}); end
   endtask

   task automatic test_illegal();
      IM_OUT = 32'hFC000000;
      @(negedge clk);
      checks++; if ({D_En, halted} !== 2'b00) begin errors++; $display("FAIL ill_decode got %b want 00", {D_En, halted}); end
      @(negedge clk);
      checks++; if ({halted, trap, im_rd} !== 4'b1010) begin errors++; $display("FAIL ill_halt got %b want 1010", {halted, trap, im_rd}); end
      repeat (2) @(negedge clk);
      checks++; if ({halted, trap} !== 3'b101) begin errors++; $display("FAIL ill_sticky got %b want 101", {halted, trap}); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_lw();
      test_sw();
      test_branches();
      test_mult_mfhi();
      test_ori_j();
      test_overflow();
      test_reset_mid_exec();
      test_illegal();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
